// File: rtl/crc16_frame_tx.sv
// Captures a data word, waits for the CRC16 engine's result for it, then transmits {data, crc}
// serially MSB first. The frame is dropped with a timeout pulse if the CRC never arrives.
module crc16_frame_tx #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_din_valid,
  input  logic [15:0] i_din,
  input  logic        i_crc_valid,
  input  logic [15:0] i_crc,
  output logic        o_ready,
  output logic        o_tx_valid,
  output logic        o_tx_bit,
  output logic        o_tx_sof,
  output logic        o_tx_eof,
  output logic        o_err_timeout,
  output logic        o_overrun
);
  // state    | meaning
  // IDLE     | ready to accept a data word
  // WAIT_CRC | data word held, waiting for the CRC engine result
  // SHIFT    | transmitting {data, crc}, one bit per cycle, MSB first
  typedef enum logic [1:0] {IDLE, WAIT_CRC, SHIFT} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] sr, sr_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        err_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      sr            <= '0;
      timer         <= '0;
      cnt           <= '0;
      o_ready       <= 1'b1;
      o_tx_valid    <= 1'b0;
      o_tx_bit      <= 1'b0;
      o_tx_sof      <= 1'b0;
      o_tx_eof      <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_nxt;
      sr            <= sr_nxt;
      timer         <= timer_nxt;
      cnt           <= cnt_nxt;
      // outputs are registered from the next-state values so they line up with the state
      o_ready       <= (state_nxt == IDLE);
      o_tx_valid    <= (state_nxt == SHIFT);
      o_tx_bit      <= (state_nxt == SHIFT) && sr_nxt[31];
      o_tx_sof      <= (state_nxt == SHIFT) && (cnt_nxt == 5'd0);
      o_tx_eof      <= (state_nxt == SHIFT) && (cnt_nxt == 5'd31);
      o_err_timeout <= err_nxt;
      o_overrun     <= i_din_valid && (state != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_din_valid) begin
          sr_nxt[31:16] = i_din;
          timer_nxt     = '0;
          if (i_crc_valid) begin
            sr_nxt[15:0] = i_crc;
            cnt_nxt      = '0;
            state_nxt    = SHIFT;
          end else begin
            state_nxt = WAIT_CRC;
          end
        end
      end
      WAIT_CRC: begin
        // a CRC arriving on the timeout cycle still wins
        if (i_crc_valid) begin
          sr_nxt[15:0] = i_crc;
          cnt_nxt      = '0;
          state_nxt    = SHIFT;
        end else if (timer == TIMER_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      SHIFT: begin
        sr_nxt  = {sr[30:0], 1'b0};
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'd31) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/crc16_frame_tx.md
# crc16_frame_tx

Downstream stage of the CRC16 engine. Captures one 16-bit data word when upstream presents it, waits for the CRC16 engine's result for that word, and transmits a 32-bit frame serially, MSB first: data word, then CRC word. Raises a timeout error if the CRC never arrives. Outputs one bit per clock, with start-of-frame and end-of-frame markers, to the serial line driver.

## Interface
- TIMEOUT, 16: maximum number of cycles spent in WAIT_CRC before the frame is dropped; legal range 2..255.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_din_valid  in  1  one-cycle strobe; i_din is valid.
- i_din  in  16  data word. This is the same word presented to the CRC16 engine.
- i_crc_valid  in  1  CRC16 engine output valid (engine o_dout_valid).
- i_crc  in  16  CRC16 engine result (engine o_dout).
- o_ready  out  1  block can accept a new word.
- o_tx_valid  out  1  o_tx_bit carries a frame bit.
- o_tx_bit  out  1  serial data, MSB first.
- o_tx_sof  out  1  high with the first frame bit (bit 31).
- o_tx_eof  out  1  high with the last frame bit (bit 0).
- o_err_timeout  out  1  one-cycle pulse when a frame is dropped because no CRC arrived.
- o_overrun  out  1  one-cycle pulse when i_din_valid arrives while o_ready=0; that word is discarded.

## Operation
- FSM states: IDLE, WAIT_CRC, SHIFT. The reset state is IDLE.
- Reset values: o_ready=1; all other outputs 0; data, crc, timer and bit counter all 0.
- IDLE (o_ready=1):
  - On i_din_valid, latch i_din and clear the timer.
  - If i_crc_valid is also high in that same cycle (zero-latency engine), latch i_crc as well and go to SHIFT.
  - Otherwise go to WAIT_CRC.
  - i_crc_valid without i_din_valid is ignored.
- WAIT_CRC (o_ready=0):
  - If i_crc_valid, latch i_crc and go to SHIFT.
  - Else if timer==TIMEOUT-1, pulse o_err_timeout and go to IDLE; the frame is dropped.
  - Else timer+1.
  - If i_crc_valid and the timeout hit occur in the same cycle, i_crc_valid wins.
- SHIFT (o_ready=0):
  - The 32-bit shift register holds {data, crc}.
  - Each cycle, output the MSB and shift left; the bit counter counts 0..31.
  - o_tx_sof=1 at count 0; o_tx_eof=1 at count 31.
  - After count 31, go to IDLE.
- i_crc_valid outside IDLE or WAIT_CRC is ignored.
- i_din_valid outside IDLE pulses o_overrun the next cycle and has no other effect.
- Timer is 8 bits wide; the bit counter is 5 bits wide and wraps only at frame end.
- When o_tx_valid=0, o_tx_bit, o_tx_sof and o_tx_eof are all 0.
- Asserting i_rst_n mid-frame aborts immediately: outputs go to their reset values and the state goes to IDLE; no partial eof is produced.

## Timing
- All outputs are registered.
- i_din_valid accepted at cycle T: o_ready=0 from T+1.
- i_crc_valid accepted at cycle C: first bit (sof) at C+1, eof at C+32, o_ready=1 at C+33.
- Zero-latency CRC (i_din_valid and i_crc_valid both at T): sof at T+1.
- Timeout, when i_din_valid is accepted at T with no CRC: o_err_timeout at T+TIMEOUT+1 and o_ready=1 at the same cycle.
- A CRC arriving in the last allowed cycle, T+TIMEOUT, is accepted.
- Back-to-back frames: a new i_din_valid is legal in the cycle o_ready returns, giving a minimum period of 33 cycles with a zero-latency CRC.

## Test plan
- Basic frame:
  - Stimulus: reset, then i_din=16'hAAAA, i_din_valid at T, i_crc=16'h1234 valid at T+2.
  - Required response: sof at T+3; 32-bit stream 1010_1010_1010_1010_0001_0010_0011_0100; eof at T+34; o_ready=1 at T+35.
- Zero-latency CRC:
  - Stimulus: i_din=16'h5555 and i_crc=16'hFFFF valid together.
  - Required response: sof next cycle; stream 0101...0101 followed by sixteen 1s.
- Timeout:
  - Stimulus: i_din_valid with no i_crc_valid, TIMEOUT=16.
  - Required response: o_err_timeout exactly at T+17; no o_tx_valid at any point; a following frame transmits normally.
- Boundary CRC:
  - Stimulus: i_crc_valid exactly at T+16.
  - Required response: frame is sent; no o_err_timeout.
- Overrun:
  - Stimulus: i_din_valid during SHIFT.
  - Required response: one-cycle o_overrun pulse; the current frame bits are unchanged.
- Reset mid-frame:
  - Stimulus: i_rst_n low at bit 10.
  - Required response: o_tx_valid=0, o_tx_eof is never asserted, o_ready=1 while in reset; the next frame is correct.
